// File: rtl/mmio_led_pwm.sv
// Memory-mapped multi-channel LED PWM controller; shadowed duties load at period wrap. rdata and led are
// registered (1 cycle), no backpressure. Define LED_BLINK_EN to add the BLINK mask register and blink gate.
module mmio_led_pwm #(
   parameter int BASE_ADDR  = 128,
   parameter int CHANNELS   = 3,
   parameter int PWM_WIDTH  = 8,
   parameter int PRESCALE   = 1,
   parameter int BLINK_LOG2 = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                write,
   input  logic                read,
   input  logic [7:0]          address,
   input  logic [7:0]          wdata,
   output logic [7:0]          rdata,
   output logic [CHANNELS-1:0] led
);

   localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
   localparam logic [7:0]      BASE    = 8'(BASE_ADDR);

   if (CHANNELS < 1 || CHANNELS > 8 || PWM_WIDTH < 1 || PWM_WIDTH > 8 || PRESCALE < 1 ||
       BLINK_LOG2 < 0 || BASE_ADDR + CHANNELS + 1 > 255) begin : g_param_check
      $error("mmio_led_pwm: illegal parameter combination");
   end

   logic [CHANNELS-1:0]  enable;
   logic [PWM_WIDTH-1:0] duty_shadow [CHANNELS];
   logic [PWM_WIDTH-1:0] duty_active [CHANNELS];
   logic [PS_W-1:0]      presc;
   logic [PWM_WIDTH-1:0] counter;
   logic                 tick;
   logic                 wrap;
   logic                 in_win;
   logic [7:0]           offset;
   logic [7:0]           rd_mux;
   logic [CHANNELS-1:0]  gate;
   logic [CHANNELS-1:0]  led_next;

   assign offset = address - BASE;
   assign in_win = (address >= BASE);
   assign tick   = (presc == PS_LAST);
   assign wrap   = tick && (counter == '1);

`ifdef LED_BLINK_EN
   localparam int              BL_W    = (BLINK_LOG2 > 0) ? BLINK_LOG2 : 1;
   localparam logic [BL_W-1:0] BL_LAST = BL_W'((1 << BLINK_LOG2) - 1);

   logic [CHANNELS-1:0] blink_mask;
   logic [BL_W-1:0]     blink_cnt;
   logic                phase;

   always_ff @(posedge clk) begin
      if (!rst) begin
         blink_mask <= '0;
         blink_cnt  <= '0;
         phase      <= 1'b0;
      end else begin
         if (write && in_win && offset == 8'(CHANNELS + 1))
            blink_mask <= wdata[CHANNELS-1:0];
         if (wrap) begin
            if (blink_cnt == BL_LAST) begin
               blink_cnt <= '0;
               phase     <= ~phase;
            end else begin
               blink_cnt <= blink_cnt + 1'b1;
            end
         end
      end
   end

   // Masked channels are dark during phase 0.
   assign gate = phase ? '1 : ~blink_mask;
`else
   assign gate = '1;
`endif

   always_comb begin
      rd_mux = '0;
      if (in_win) begin
         if (offset == 8'd0)
            rd_mux[CHANNELS-1:0] = enable;
         for (int i = 0; i < CHANNELS; i++) begin
            if (offset == 8'(i + 1))
               rd_mux[PWM_WIDTH-1:0] = duty_shadow[i];
         end
`ifdef LED_BLINK_EN
         if (offset == 8'(CHANNELS + 1))
            rd_mux[CHANNELS-1:0] = blink_mask;
`endif
      end
   end

   always_comb begin
      led_next = '0;
      for (int i = 0; i < CHANNELS; i++)
         led_next[i] = enable[i] && (counter < duty_active[i]) && gate[i];
   end

   // Active duties sample the shadow on the wrap edge, so a same-cycle write lands one period later.
   always_ff @(posedge clk) begin
      if (!rst) begin
         enable  <= '0;
         presc   <= '0;
         counter <= '0;
         led     <= '0;
         rdata   <= '0;
         for (int i = 0; i < CHANNELS; i++) begin
            duty_shadow[i] <= '0;
            duty_active[i] <= '0;
         end
      end else begin
         presc <= tick ? '0 : presc + 1'b1;
         if (tick)
            counter <= counter + 1'b1;
         if (write && in_win && offset == 8'd0)
            enable <= wdata[CHANNELS-1:0];
         for (int i = 0; i < CHANNELS; i++) begin
            if (write && in_win && offset == 8'(i + 1))
               duty_shadow[i] <= wdata[PWM_WIDTH-1:0];
            if (wrap)
               duty_active[i] <= duty_shadow[i];
         end
         if (read && !write)
            rdata <= rd_mux;
         led <= led_next;
      end
   end

endmodule

// File: tb/tb_mmio_led_pwm.sv
// Directed bench for mmio_led_pwm: default instance plus a PRESCALE=4 instance; expectations queued then checked.
module tb_mmio_led_pwm;
   localparam logic [7:0] BASE = 8'd128;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       write = 1'b0, read = 1'b0;
   logic [7:0] address = '0, wdata = '0;
   logic [7:0] rdata;
   logic [2:0] led;

   logic       write2 = 1'b0, read2 = 1'b0;
   logic [7:0] address2 = '0, wdata2 = '0;
   logic [7:0] rdata2;
   logic [2:0] led2;

   mmio_led_pwm #(.BASE_ADDR(128), .CHANNELS(3), .PWM_WIDTH(8), .PRESCALE(1), .BLINK_LOG2(1)) dut (
      .clk(clk), .rst(rst), .write(write), .read(read), .address(address),
      .wdata(wdata), .rdata(rdata), .led(led)
   );

   mmio_led_pwm #(.BASE_ADDR(128), .CHANNELS(3), .PWM_WIDTH(8), .PRESCALE(4), .BLINK_LOG2(1)) dut4 (
      .clk(clk), .rst(rst), .write(write2), .read(read2), .address(address2),
      .wdata(wdata2), .rdata(rdata2), .led(led2)
   );

   always #5 clk = ~clk;

   int          total = 0;
   int          bad = 0;
   logic [31:0] exp_q[$];
   int          other_hi = 0;
   int          hi, per, hi2;
   bit          ok, prevb, done;

   task automatic check(input string tag, input logic [31:0] obs);
      logic [31:0] exp;
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $error("FAIL %s scoreboard empty, observed=%0d", tag, obs);
         return;
      end
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // All bus/measure tasks start and end on a falling edge.
   task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
      write = 1'b1; address = a; wdata = d;
      @(negedge clk);
      write = 1'b0;
   endtask

   task automatic bus_read(input string tag, input logic [7:0] a, input logic [7:0] exp);
      read = 1'b1; address = a;
      exp_q.push_back(32'(exp));
      @(negedge clk);
      read = 1'b0;
      check(tag, 32'(rdata));
   endtask

   task automatic bus2_write(input logic [7:0] a, input logic [7:0] d);
      write2 = 1'b1; address2 = a; wdata2 = d;
      @(negedge clk);
      write2 = 1'b0;
   endtask

   task automatic wait_rise(input int need_low, output bit found);
      int low;
      low = 0;
      found = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         if (led[0] && low >= need_low) begin
            found = 1'b1;
            break;
         end
         low = led[0] ? 0 : low + 1;
         @(negedge clk);
      end
   endtask

   // Samples n cycles of led[0]; optionally issues one write at sample index wr_at.
   task automatic count_hi(input int n, input int wr_at, input logic [7:0] wa,
                           input logic [7:0] wd, output int h);
      h = 0;
      for (int i = 0; i < n; i++) begin
         if (led[0]) h++;
         if (led[2:1] != 2'b00) other_hi++;
         write = (i == wr_at); address = wa; wdata = wd;
         @(negedge clk);
      end
      write = 1'b0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      exp_q.push_back(0); check("reset_led", 32'(led));
      exp_q.push_back(0); check("reset_rdata", 32'(rdata));
      exp_q.push_back(0); check("reset_led_p4", 32'(led2));
      rst = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 5; i++) bus_read("reset_readback", BASE + 8'(i), 8'h00);
      exp_q.push_back(0); check("led_idle", 32'(led));

`ifndef LED_BLINK_EN
      bus_write(BASE + 8'd4, 8'hFF);
      bus_read("unmapped_blink", BASE + 8'd4, 8'h00);
`endif

      bus_write(BASE + 8'd1, 8'h40);
      bus_write(BASE, 8'h01);
      bus_read("duty0_readback", BASE + 8'd1, 8'h40);
      wait_rise(1, ok);
      exp_q.push_back(1); check("first_rise", 32'(ok));
      exp_q.push_back(64); count_hi(256, -1, BASE, 8'h00, hi); check("duty40_p1", 32'(hi));
      exp_q.push_back(64); count_hi(256, -1, BASE, 8'h00, hi); check("duty40_p2", 32'(hi));

      exp_q.push_back(64);  count_hi(256, 128, BASE + 8'd1, 8'hC0, hi); check("glitch_cur", 32'(hi));
      exp_q.push_back(192); count_hi(256, -1, BASE, 8'h00, hi);          check("glitch_next", 32'(hi));
      bus_read("glitch_readback", BASE + 8'd1, 8'hC0);

      bus_write(BASE + 8'd1, 8'h40);
      wait_rise(1, ok);
      exp_q.push_back(1); check("realign_rise", 32'(ok));
      exp_q.push_back(64); count_hi(256, 254, BASE + 8'd1, 8'h20, hi); check("wrapwr_cur", 32'(hi));
      exp_q.push_back(64); count_hi(256, -1, BASE, 8'h00, hi);         check("wrapwr_deferred", 32'(hi));
      exp_q.push_back(32); count_hi(256, -1, BASE, 8'h00, hi);         check("wrapwr_applied", 32'(hi));

      bus_write(BASE + 8'd1, 8'h00);
      count_hi(300, -1, BASE, 8'h00, hi);
      exp_q.push_back(0); count_hi(512, -1, BASE, 8'h00, hi); check("duty00", 32'(hi));

      bus_write(BASE + 8'd1, 8'hFF);
      wait_rise(1, ok);
      exp_q.push_back(1); check("ff_rise", 32'(ok));
      exp_q.push_back(255); count_hi(256, -1, BASE, 8'h00, hi); check("dutyFF_p1", 32'(hi));
      exp_q.push_back(255); count_hi(256, -1, BASE, 8'h00, hi); check("dutyFF_p2", 32'(hi));
      exp_q.push_back(0); check("other_channels_off", 32'(other_hi));

      bus2_write(BASE + 8'd1, 8'h40);
      bus2_write(BASE, 8'h01);
      ok = 1'b0;
      prevb = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if (led2[0] && !prevb) begin
            ok = 1'b1;
            break;
         end
         prevb = led2[0];
         @(negedge clk);
      end
      exp_q.push_back(1); check("p4_rise", 32'(ok));
      per = 0; hi2 = 0; prevb = 1'b1; done = 1'b0;
      for (int i = 0; i < 3000 && !done; i++) begin
         if (led2[0] && !prevb) begin
            done = 1'b1;
         end else begin
            if (led2[0]) hi2++;
            per++;
            prevb = led2[0];
            @(negedge clk);
         end
      end
      exp_q.push_back(1024); check("p4_period", 32'(per));
      exp_q.push_back(256);  check("p4_high", 32'(hi2));

      bus_read("read_addr127", 8'd127, 8'h00);
      bus_write(8'd200, 8'hAA);
      bus_read("wr200_enable", BASE, 8'h01);
      bus_read("wr200_duty0", BASE + 8'd1, 8'hFF);
      bus_read("wr200_duty1", BASE + 8'd2, 8'h00);
      bus_read("wr200_duty2", BASE + 8'd3, 8'h00);

      bus_read("pre_wrrd", BASE, 8'h01);
      write = 1'b1; read = 1'b1; address = BASE + 8'd2; wdata = 8'h55;
      @(negedge clk);
      write = 1'b0; read = 1'b0;
      exp_q.push_back(1); check("wrrd_rdata_hold", 32'(rdata));
      bus_read("wrrd_written", BASE + 8'd2, 8'h55);
      bus_write(BASE + 8'd2, 8'h00);

      bus_write(BASE, 8'hFF);
      bus_read("enable_ff", BASE, 8'h07);
      bus_write(BASE, 8'h01);

`ifdef LED_BLINK_EN
      bus_write(BASE + 8'd1, 8'h80);
      bus_write(BASE + 8'd4, 8'h01);
      bus_read("blink_readback", BASE + 8'd4, 8'h01);
      wait_rise(300, ok);
      exp_q.push_back(1); check("blink_rise", 32'(ok));
      exp_q.push_back(128); count_hi(256, -1, BASE, 8'h00, hi); check("blink_on1", 32'(hi));
      exp_q.push_back(128); count_hi(256, -1, BASE, 8'h00, hi); check("blink_on2", 32'(hi));
      exp_q.push_back(0);   count_hi(256, -1, BASE, 8'h00, hi); check("blink_off1", 32'(hi));
      exp_q.push_back(0);   count_hi(256, -1, BASE, 8'h00, hi); check("blink_off2", 32'(hi));
      exp_q.push_back(128); count_hi(256, -1, BASE, 8'h00, hi); check("blink_on3", 32'(hi));
`endif

      wait_rise(1, ok);
      count_hi(10, -1, BASE, 8'h00, hi);
      exp_q.push_back(1); check("pre_reset_on", 32'(led[0]));
      rst = 1'b0;
      @(negedge clk);
      exp_q.push_back(0); check("midreset_led", 32'(led));
      exp_q.push_back(0); check("midreset_rdata", 32'(rdata));
      rst = 1'b1;
      bus_read("midreset_duty0", BASE + 8'd1, 8'h00);
      bus_read("midreset_enable", BASE, 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
